// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, NOP encoding and PC step.
package mips_pkg;

  // Fetch-stage handshake states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // sll $0,$0,0 -- the canonical MIPS no-op.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline stage register holding an instruction word, its PC+4 and a valid bit.
// Flush has priority over load; with neither asserted the contents are held.
// Written generically so later stage registers can reuse it.
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  // Stage register: squash to a bubble on flush, capture on load, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= NOP_WORD;
      r_pc4   <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_instr <= NOP_WORD;
      r_pc4   <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (load) begin
      r_instr <= instr_in;
      r_pc4   <= pc4_in;
      r_valid <= 1'b1;
    end
  end

  assign instr = r_instr;
  assign pc4   = r_pc4;
  assign valid = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: req/ack handshake with instruction memory, IF/ID register
// load, one-entry hold buffer for decode stalls, and PC stall/confirm control.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_cycles.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = MIPS_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        halt,
  input  logic        id_stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        pc_stall,
  output logic        pc_confirm,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic [31:0] r_addr_q;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc4;

  logic        w_advance;
  logic        w_load;
  logic        w_hold_capture;
  logic        w_stall_cycle;
  logic [31:0] w_pc4;
  logic [31:0] w_load_instr;
  logic [31:0] w_load_pc4;

  // PC+4 wraps naturally at 32 bits.
  assign w_pc4 = pc + PC_STEP;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake/control decode; flush overrides the normal flow.
  always_comb begin
    w_state_next   = r_state;
    w_advance      = 1'b0;
    w_load         = 1'b0;
    w_hold_capture = 1'b0;
    w_stall_cycle  = 1'b0;
    imem_req       = 1'b0;
    imem_addr      = pc;
    w_load_instr   = imem_rdata;
    w_load_pc4     = w_pc4;

    case (r_state)
      IDLE: begin
        if (!halt) begin
          w_state_next = REQ;
        end
      end

      REQ: begin
        imem_req      = 1'b1;
        imem_addr     = pc;
        w_stall_cycle = !imem_ack;
        if (flush) begin
          // An ack this cycle retires the request (data dropped); otherwise
          // it is still in flight and must be drained at the old address.
          w_state_next = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          if (id_stall) begin
            w_hold_capture = 1'b1;
            w_state_next   = HOLD;
          end else begin
            w_load       = 1'b1;
            w_advance    = 1'b1;
            w_state_next = halt ? IDLE : REQ;
          end
        end
      end

      HOLD: begin
        w_stall_cycle = 1'b1;
        w_load_instr  = r_hold_instr;
        w_load_pc4    = r_hold_pc4;
        if (flush) begin
          w_state_next = halt ? IDLE : REQ;
        end else if (!id_stall) begin
          w_load       = 1'b1;
          w_advance    = 1'b1;
          w_state_next = halt ? IDLE : REQ;
        end
      end

      DRAIN: begin
        imem_req      = 1'b1;
        imem_addr     = r_addr_q;
        w_stall_cycle = 1'b1;
        if (!flush && imem_ack) begin
          w_state_next = REQ;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // A taken branch always lets the PC load its redirect target.
    if (flush) begin
      w_advance = 1'b1;
    end
  end

  assign pc_confirm = w_advance;
  assign pc_stall   = !w_advance;

  // Remember the address of the in-flight request so a drain can keep it stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_q <= 32'h0000_0000;
    end else if (r_state == REQ) begin
      r_addr_q <= pc;
    end
  end

  // One-entry hold buffer for a word that arrived while decode was stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_instr <= NOP_WORD;
      r_hold_pc4   <= 32'h0000_0000;
    end else if (flush) begin
      r_hold_instr <= NOP_WORD;
      r_hold_pc4   <= 32'h0000_0000;
    end else if (w_hold_capture) begin
      r_hold_instr <= imem_rdata;
      r_hold_pc4   <= w_pc4;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .flush    (flush),
    .instr_in (w_load_instr),
    .pc4_in   (w_load_pc4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall_cycles;

  // Count valid IF/ID loads and cycles spent waiting on memory or decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched      <= 32'h0000_0000;
      r_perf_stall_cycles <= 32'h0000_0000;
    end else begin
      if (w_load && !flush) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_stall_cycle) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
    end
  end

  assign perf_fetched      = r_perf_fetched;
  assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: reset, zero-wait fetch, wait states,
// decode-stall hold, flush with drain, PC+4 wrap, halt, optional perf counters.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        halt;
  logic        id_stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_stall;
  logic        pc_confirm;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
`endif

  int n_compared;
  int n_mismatched;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .halt        (halt),
    .id_stall    (id_stall),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_stall    (pc_stall),
    .pc_confirm  (pc_confirm),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset      = 1'b1;
    pc         = 32'h0;
    halt       = 1'b0;
    id_stall   = 1'b0;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;

    step();
    step();
    check("rst_req",     {31'd0, imem_req},    32'd0);
    check("rst_instr",   if_id_instr,          32'h0000_0000);
    check("rst_pc4",     if_id_pc4,            32'h0);
    check("rst_valid",   {31'd0, if_id_valid}, 32'd0);
    check("rst_stall",   {31'd0, pc_stall},    32'd1);
    check("rst_confirm", {31'd0, pc_confirm},  32'd0);

    // Release reset; FSM sits in IDLE until the next edge.
    reset = 1'b0;
    #1;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    $display("txn: first request addr=%h req=%b", imem_addr, imem_req);
    check("first_req",  {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr,         32'h0);

    // Zero-wait fetch.
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_0005;
    #1;
    check("zw_confirm", {31'd0, pc_confirm}, 32'd1);
    step();
    $display("txn: zero-wait fetch instr=%h pc4=%h", if_id_instr, if_id_pc4);
    check("zw_instr", if_id_instr,          32'h2008_0005);
    check("zw_pc4",   if_id_pc4,            32'h4);
    check("zw_valid", {31'd0, if_id_valid}, 32'd1);

    // Three wait cycles, then ack.
    pc       = 32'h4;
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait_stall",   {31'd0, pc_stall},   32'd1);
      check("wait_confirm", {31'd0, pc_confirm}, 32'd0);
      check("wait_addr",    imem_addr,           32'h4);
      step();
    end
    check("wait_instr_kept", if_id_instr, 32'h2008_0005);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    #1;
    check("wait_ack_confirm", {31'd0, pc_confirm}, 32'd1);
    step();
    $display("txn: 3-wait fetch instr=%h pc4=%h", if_id_instr, if_id_pc4);
    check("wait_instr", if_id_instr, 32'h1111_1111);
    check("wait_pc4",   if_id_pc4,   32'h8);

    // Ack arrives while decode is stalled: word parked in the hold buffer.
    pc         = 32'h8;
    imem_rdata = 32'h8C09_0000;
    id_stall   = 1'b1;
    #1;
    check("hs_confirm", {31'd0, pc_confirm}, 32'd0);
    step();
    imem_ack = 1'b0;
    #1;
    check("hold_req",     {31'd0, imem_req},   32'd0);
    check("hold_instr",   if_id_instr,         32'h1111_1111);
    check("hold_pc4",     if_id_pc4,           32'h8);
    check("hold_confirm", {31'd0, pc_confirm}, 32'd0);
    step();
    check("hold2_instr", if_id_instr,        32'h1111_1111);
    check("hold2_req",   {31'd0, imem_req},  32'd0);
    id_stall = 1'b0;
    #1;
    check("unhold_confirm", {31'd0, pc_confirm}, 32'd1);
    step();
    pc = 32'hC;
    #1;
    $display("txn: hold release instr=%h pc4=%h", if_id_instr, if_id_pc4);
    check("unhold_instr", if_id_instr,       32'h8C09_0000);
    check("unhold_pc4",   if_id_pc4,         32'hC);
    check("unhold_req",   {31'd0, imem_req}, 32'd1);

    // Flush while a request to 0x40 is waiting.
    pc = 32'h40;
    step();
    flush = 1'b1;
    #1;
    check("fl_confirm", {31'd0, pc_confirm}, 32'd1);
    check("fl_addr",    imem_addr,           32'h40);
    step();
    flush = 1'b0;
    pc    = 32'h100;
    #1;
    $display("txn: flush instr=%h valid=%b drain addr=%h", if_id_instr, if_id_valid, imem_addr);
    check("fl_instr",      if_id_instr,          32'h0000_0000);
    check("fl_pc4",        if_id_pc4,            32'h0);
    check("fl_valid",      {31'd0, if_id_valid}, 32'd0);
    check("drain_req",     {31'd0, imem_req},    32'd1);
    check("drain_addr",    imem_addr,            32'h40);
    check("drain_confirm", {31'd0, pc_confirm},  32'd0);
    step();
    check("drain2_addr", imem_addr, 32'h40);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("drain_ack_confirm", {31'd0, pc_confirm}, 32'd0);
    step();
    imem_ack = 1'b0;
    #1;
    check("post_drain_valid", {31'd0, if_id_valid}, 32'd0);
    check("post_drain_instr", if_id_instr,          32'h0000_0000);
    check("post_drain_addr",  imem_addr,            32'h100);
    imem_ack   = 1'b1;
    imem_rdata = 32'h03E0_0008;
    step();
    $display("txn: target fetch instr=%h pc4=%h", if_id_instr, if_id_pc4);
    check("tgt_instr", if_id_instr, 32'h03E0_0008);
    check("tgt_pc4",   if_id_pc4,   32'h104);

    // PC+4 wraps at the top of the address space.
    pc         = 32'hFFFF_FFFC;
    imem_rdata = 32'h1234_5678;
    step();
    $display("txn: wrap fetch instr=%h pc4=%h", if_id_instr, if_id_pc4);
    check("wrap_instr", if_id_instr, 32'h1234_5678);
    check("wrap_pc4",   if_id_pc4,   32'h0);

    // Halt during an outstanding request: it completes, then IDLE.
    pc       = 32'h0;
    imem_ack = 1'b0;
    halt     = 1'b1;
    step();
    check("halt_pending_req", {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hAAAA_5555;
    step();
    imem_ack = 1'b0;
    #1;
    $display("txn: halt completion instr=%h req=%b", if_id_instr, imem_req);
    check("halt_instr",   if_id_instr,         32'hAAAA_5555);
    check("halt_pc4",     if_id_pc4,           32'h4);
    check("halt_req",     {31'd0, imem_req},   32'd0);
    check("halt_stall",   {31'd0, pc_stall},   32'd1);
    check("halt_confirm", {31'd0, pc_confirm}, 32'd0);
    step();
    check("halt_idle_req", {31'd0, imem_req}, 32'd0);

`ifdef FETCH_PERF_CNT_EN
    // Six valid loads; stall cycles: 3 waits + 2 hold + 2 REQ-no-ack around flush
    // + 2 drain + 1 pending before halt completion = 10.
    $display("txn: perf fetched=%0d stall=%0d", perf_fetched, perf_stall_cycles);
    check("perf_fetched", perf_fetched,      32'd6);
    check("perf_stall",   perf_stall_cycles, 32'd10);
`endif

    // Asynchronous reset mid-request drops the request immediately.
    halt = 1'b0;
    step();
    check("re_req", {31'd0, imem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_req",   {31'd0, imem_req},    32'd0);
    check("async_rst_valid", {31'd0, if_id_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS pipeline, directly downstream of the program counter. It takes the current PC, runs a req/ack handshake with instruction memory, and loads the fetched word into the IF/ID pipeline register. It drives the PC's `stall`/`confirm` inputs so the PC advances only when an instruction is accepted or a branch redirect occurs. It holds one fetched instruction while decode is stalled.

## Interface
- `NOP_WORD`, default 32'h0000_0000: value loaded into `if_id_instr` on reset and on flush (`sll $0,$0,0`).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `pc` input 32: current PC (the PC register's `pc_out`).
- `halt` input 1: stops issuing new fetches.
- `id_stall` input 1: decode cannot accept a new IF/ID entry this cycle.
- `flush` input 1: branch/jump taken; squash the fetch path; PC loads its redirect target.
- `imem_req` output 1: instruction-memory request.
- `imem_addr` output 32: word address of the request.
- `imem_ack` input 1: memory has returned data this cycle.
- `imem_rdata` input 32: instruction word, valid when `imem_ack`=1.
- `pc_stall` output 1: to the PC's `stall`.
- `pc_confirm` output 1: to the PC's `confirm`.
- `if_id_instr` output 32: IF/ID instruction.
- `if_id_pc4` output 32: IF/ID PC+4 of that instruction.
- `if_id_valid` output 1: IF/ID entry is a real instruction.

## Operation
- FSM states: IDLE, REQ, HOLD, DRAIN.
- `advance` = (REQ ∧ `imem_ack` ∧ ¬`id_stall` ∧ ¬`flush`) ∨ (HOLD ∧ ¬`id_stall` ∧ ¬`flush`) ∨ `flush`.
- `pc_confirm` = `advance`; `pc_stall` = ¬`advance`. Both are combinational.
- `imem_req` = state ∈ {REQ, DRAIN}. `imem_addr` = `pc` in REQ and `addr_q` in DRAIN. `addr_q` loads `pc` every cycle the FSM is in REQ.
- IDLE: go to REQ when ¬`halt`.
- REQ:
  - `imem_ack` ∧ ¬`id_stall`: load IF/ID with `imem_rdata`, `pc`+4, valid=1. Stay in REQ, or go to IDLE if `halt`.
  - `imem_ack` ∧ `id_stall`: capture data and `pc`+4 into the hold buffer; go to HOLD.
  - No ack: stay in REQ; IF/ID unchanged.
- HOLD: `imem_req`=0. When ¬`id_stall`: move the hold buffer into IF/ID; go to REQ, or to IDLE if `halt`.
- `id_stall` with no new entry: IF/ID keeps its contents.
- `flush` (priority over everything except reset):
  - IF/ID ← `NOP_WORD`, pc4=0, valid=0; hold buffer discarded; `pc_confirm`=1.
  - In REQ without ack: go to DRAIN.
  - In REQ with ack: the ack completes the request and the data is discarded; go to REQ.
  - In DRAIN: stay in DRAIN.
  - Otherwise: go to REQ (or IDLE if `halt`).
- DRAIN: hold `imem_req` and `addr_q` until `imem_ack`. Discard the returned data, then go to REQ.
- Handshake rule: once `imem_req` rises, `imem_addr` stays stable until the ack cycle. Address changes only after an ack.
- `halt` never aborts an outstanding request; a pending REQ completes normally.
- Arithmetic: `pc`+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC → 0).

## Timing
- Reset values: state=IDLE, `imem_req`=0, `if_id_instr`=`NOP_WORD`, `if_id_pc4`=0, `if_id_valid`=0, `addr_q`=0, hold buffer cleared.
- `pc_confirm`=0 and `pc_stall`=1 in IDLE, because `advance`=0.
- Reset asserted mid-request drops `imem_req` immediately; the memory must tolerate this.
- First request: `imem_req` rises one cycle after reset deasserts, provided `halt`=0.
- Zero-wait memory (ack in the request cycle) sustains 1 instruction/cycle. IF/ID and the PC update on the same edge.
- N wait cycles add N cycles per instruction.
- Flush to the first fetch at the target: 1 cycle. If a request is outstanding, the drain wait is added.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `perf_fetched` [31:0] and `perf_stall_cycles` [31:0].
  - `perf_fetched` increments on each IF/ID load with valid=1.
  - `perf_stall_cycles` increments on each cycle in REQ without ack, in HOLD, or in DRAIN.
  - Both reset to 0 and wrap.
- Undefined: neither port nor counter logic exists.

## Structure
- Shared package `mips_pkg` holds:
  - the fetch state enum `fetch_state_t` (IDLE, REQ, HOLD, DRAIN);
  - constant `MIPS_NOP` = 32'h0000_0000;
  - localparam `PC_STEP` = 4.
- One sub-module, `if_id_reg`: the IF/ID register. It has load, flush and hold control and the valid bit, and is reused by later stage registers.

## Test plan
- Reset, then pc=0x0000_0000 with `imem_ack` held at 1 and rdata=0x2008_0005 → `imem_req`=1 one cycle after reset; next edge gives `if_id_instr`=0x2008_0005, `if_id_pc4`=4, valid=1, `pc_confirm`=1.
- Ack delayed 3 cycles → `pc_stall`=1 and `pc_confirm`=0 for 3 cycles, `imem_addr` stable; `pc_confirm`=1 in the ack cycle.
- `id_stall`=1 when the ack arrives with rdata=0x8C09_0000 → state HOLD, IF/ID unchanged, `imem_req`=0. `id_stall` drops → IF/ID=0x8C09_0000, then REQ.
- `flush` while waiting for ack at addr 0x40 → IF/ID=NOP with valid=0, `pc_confirm`=1. DRAIN holds addr 0x40 until ack; that data is not loaded; the next request uses the new `pc`.
- pc=0xFFFF_FFFC fetched → `if_id_pc4`=0x0000_0000. `halt`=1 during an outstanding request → the request completes, then IDLE with `imem_req`=0.
- With `FETCH_PERF_CNT_EN`: 5 fetches including 2 wait cycles → `perf_fetched`=5, `perf_stall_cycles`=2.
